// File: rtl/leb128_encoder_pkg.sv
// Shared constants and types for the LEB128 encoder: width selects, length bounds,
// value type codes and the FSM state encoding.
package leb128_encoder_pkg;

    localparam int unsigned VAL_W  = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic LEB128_I32 = 1'b0;
    localparam logic LEB128_I64 = 1'b1;

    localparam int unsigned LEB128_MAX_I32 = 5;
    localparam int unsigned LEB128_MAX_I64 = 10;

    // Stack-entry type codes (bits [65:64] of a tagged entry)
    localparam logic [1:0] TYPE_I32 = 2'd0;
    localparam logic [1:0] TYPE_I64 = 2'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    function automatic logic type_is64(input logic [1:0] type_code);
        return (type_code == TYPE_I64) ? LEB128_I64 : LEB128_I32;
    endfunction

endpackage

// File: rtl/leb128_encoder_if.sv
// Word-in / byte-out handshake bundle of the LEB128 encoder.
interface leb128_encoder_if;
    import leb128_encoder_pkg::*;

    logic [VAL_W-1:0]  in_value;
    logic              in_is64;
    logic              in_signed;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [CNT_W-1:0]  out_len;

    modport master (
        output in_value, in_is64, in_signed, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_len
    );

    modport slave (
        input  in_value, in_is64, in_signed, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, out_len
    );

endinterface

// File: rtl/leb128_step.sv
// One LEB128 step: peels seven bits off the working value and decides termination.
module leb128_step
    import leb128_encoder_pkg::*;
(
    input  logic [VAL_W-1:0]  val_i,
    input  logic              signed_i,
    output logic [VAL_W-1:0]  rest_o,
    output logic              done_o,
    output logic [BYTE_W-1:0] byte_o
);

    logic [VAL_W-1:0] sar_val;
    logic [VAL_W-1:0] shr_val;

    // Shifts kept in separate assigns so the arithmetic shift keeps its signedness
    assign sar_val = $signed(val_i) >>> 7;
    assign shr_val = val_i >> 7;
    assign rest_o  = signed_i ? sar_val : shr_val;

    // Signed stop needs the emitted bit 6 to agree with the remaining sign fill
    assign done_o = signed_i
        ? (((rest_o == '0) && !val_i[6]) || ((rest_o == '1) && val_i[6]))
        : (rest_o == '0);

    assign byte_o = {!done_o, val_i[6:0]};

endmodule

// File: rtl/leb128_encoder.sv
// Streaming LEB128 encoder: one i32/i64 word per input handshake, one byte per output
// handshake, with back-to-back words accepted on the last byte.
module leb128_encoder
    import leb128_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    leb128_encoder_if.slave   bus
);

    state_e             state_q;
    logic               out_valid_q;
    logic [VAL_W-1:0]   val_q;
    logic               signed_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [VAL_W-1:0]   rest;
    logic               done;
    logic [BYTE_W-1:0]  step_byte;
    logic [VAL_W-1:0]   load_val;
    logic               in_fire;
    logic               out_fire;

    leb128_step u_step (
        .val_i    (val_q),
        .signed_i (signed_q),
        .rest_o   (rest),
        .done_o   (done),
        .byte_o   (step_byte)
    );

    assign out_fire     = out_valid_q & bus.out_ready;
    assign bus.in_ready = reset & ((state_q == ST_IDLE) | (out_fire & done));
    assign in_fire      = bus.in_valid & bus.in_ready;

    // Widen the incoming word to the 64-bit working value
    always_comb begin
        load_val = bus.in_value;
        if (bus.in_is64 == LEB128_I32) begin
            load_val = bus.in_signed ? {{32{bus.in_value[31]}}, bus.in_value[31:0]}
                                     : {32'd0, bus.in_value[31:0]};
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? step_byte : '0;
    assign bus.out_last  = out_valid_q & done;
    assign bus.out_len   = (out_valid_q & done) ? cnt_q : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            val_q       <= '0;
            signed_q    <= 1'b0;
            cnt_q       <= '0;
        end else if (state_q == ST_IDLE) begin
            if (in_fire) begin
                state_q     <= ST_EMIT;
                out_valid_q <= 1'b1;
                val_q       <= load_val;
                signed_q    <= bus.in_signed;
                cnt_q       <= CNT_W'(1);
            end
        end else if (out_fire) begin
            if (!done) begin
                val_q <= rest;
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (in_fire) begin
                // Last byte taken while the next word is offered: no bubble
                val_q    <= load_val;
                signed_q <= bus.in_signed;
                cnt_q    <= CNT_W'(1);
            end else begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_leb128_encoder.sv
// Directed bench for leb128_encoder: expected byte streams queued at stimulus time and
// checked by a negedge monitor on every output handshake.
module tb_leb128_encoder;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] len;
        int         bound;
    } exp_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   rand_rdy = 0;
    exp_t sb[$];

    logic       stall_q = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;
    logic [3:0] hold_len;

    leb128_encoder_if bus ();

    leb128_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Queue n expected bytes; byte i is bytes_le[8*i +: 8]
    task automatic expect_seq(input logic [79:0] bytes_le, input int n, input int bound);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data  = bytes_le[8*i +: 8];
            e.last  = (i == n - 1);
            e.len   = (i == n - 1) ? 4'(n) : 4'd0;
            e.bound = bound;
            sb.push_back(e);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Offer one word until accepted, then scramble the data ports
    task automatic offer(input logic [63:0] v, input logic is64, input logic sgn);
        bit got = 0;
        bus.in_value  = v;
        bus.in_is64   = is64;
        bus.in_signed = sgn;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
            step_cycle();
        end
        bus.in_valid  = 1'b0;
        bus.in_value  = {$urandom, $urandom};
        bus.in_is64   = 1'($urandom_range(0, 1));
        bus.in_signed = 1'($urandom_range(0, 1));
        chk("accept", 64'(got), 64'd1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) ok = 1;
            else step_cycle();
        end
        chk("drain", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard compare, stall stability and length bound
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.out_valid) begin
            if (stall_q) begin
                chk("stall_data", 64'(bus.out_data), 64'(hold_data));
                chk("stall_last", 64'(bus.out_last), 64'(hold_last));
                chk("stall_len", 64'(bus.out_len), 64'(hold_len));
            end
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("stray_byte", 64'(bus.out_data), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(e.data));
                    chk("out_last", 64'(bus.out_last), 64'(e.last));
                    chk("out_len", 64'(bus.out_len), 64'(e.len));
                    if (bus.out_last) chk("len_bound", 64'(int'(bus.out_len) <= e.bound), 64'd1);
                end
            end
        end
        stall_q   <= reset && bus.out_valid && !bus.out_ready;
        hold_data <= bus.out_data;
        hold_last <= bus.out_last;
        hold_len  <= bus.out_len;
    end

    initial begin
        bit got;
        reset         = 1'b0;
        bus.in_value  = '0;
        bus.in_is64   = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_len", 64'(bus.out_len), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        expect_seq(80'h268EE5, 3, 5);
        offer(64'd624485, 1'b0, 1'b0);
        drain();
        expect_seq(80'h78BBC0, 3, 10);
        offer(64'hFFFF_FFFF_FFFE_1DC0, 1'b1, 1'b1);
        drain();
        expect_seq(80'h00C0, 2, 5);
        offer(64'hDEAD_BEEF_0000_0040, 1'b0, 1'b1);
        drain();
        expect_seq(80'h7F, 1, 5);
        offer(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
        drain();
        expect_seq(80'h0F_FFFF_FFFF, 5, 5);
        offer(64'h1234_5678_FFFF_FFFF, 1'b0, 1'b0);
        drain();
        expect_seq(80'h01FF_FFFF_FFFF_FFFF_FFFF, 10, 10);
        offer(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain();
        expect_seq(80'h7F80_8080_8080_8080_8080, 10, 10);
        offer(64'h8000_0000_0000_0000, 1'b1, 1'b1);
        drain();

        // Random backpressure with a second word waiting behind the first
        rand_rdy = 1;
        expect_seq(80'h268EE5, 3, 5);
        offer(64'd624485, 1'b0, 1'b0);
        expect_seq(80'h00, 1, 5);
        bus.in_value  = 64'd0;
        bus.in_is64   = 1'b0;
        bus.in_signed = 1'b1;
        bus.in_valid  = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                chk("b2b_on_last", {60'd0, bus.out_valid, bus.out_ready, bus.out_last, 1'b0},
                    64'hE);
                chk("b2b_last_byte", 64'(bus.out_data), 64'h26);
            end
            step_cycle();
        end
        bus.in_valid = 1'b0;
        chk("b2b_accept", 64'(got), 64'd1);
        @(negedge clk);
        chk("b2b_next_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_next_data", 64'(bus.out_data), 64'h00);
        step_cycle();
        drain();
        rand_rdy      = 0;
        bus.out_ready = 1'b1;

        // Reset right after the first byte is taken
        expect_seq(80'h268EE5, 3, 5);
        offer(64'd624485, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_in_ready2", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_quiet", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        expect_seq(80'h7F, 1, 5);
        offer(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leb128_encoder.md
# leb128_encoder

Streaming LEB128 encoder: takes one 32- or 64-bit integer per handshake and emits its signed (`varintN`) or unsigned (`varuintN`) LEB128 byte sequence, one byte per cycle, over a valid/ready byte stream. It is the producer-side counterpart of the CPU's `unpack_i64` decode path. It serializes results and immediates into WebAssembly bytecode form, for the result/trace path and for building ROM images in benches.

## Interface
Parameters:
- none; widths are fixed by the WebAssembly value types (i32/i64).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_value`  in  64  value to encode. For i32, only `[31:0]` is used.
- `in_is64`  in  1  0 = i32 (max 5 bytes), 1 = i64 (max 10 bytes).
- `in_signed`  in  1  1 = signed LEB128, 0 = unsigned.
- `in_valid`  in  1  input word offered.
- `in_ready`  out  1  encoder accepts a word this cycle.
- `out_data`  out  8  current LEB128 byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes the byte this cycle.
- `out_last`  out  1  current byte is the final byte (continuation bit 0).
- `out_len`  out  4  total byte count of the sequence. Valid when `out_valid & out_last`, otherwise 0.

## Operation
- Two states: IDLE and EMIT.
- **IDLE to EMIT**
  - Transition happens on `in_valid & in_ready`.
  - Working register `val` (64 bit) is loaded as follows:
    - i32 signed: sign-extended `in_value[31:0]`.
    - i32 unsigned: zero-extended `in_value[31:0]`.
    - i64: `in_value`.
  - `signed_q` is latched from `in_signed`, and byte counter `cnt` is set to 1.
- **Byte generation**
  - `rest = signed_q ? val >>> 7 : val >> 7`.
  - `done`:
    - unsigned: `rest == 0`.
    - signed: `(rest == 0 && !val[6]) || (rest == all-ones && val[6])`.
  - `out_data = {!done, val[6:0]}` and `out_last = done`.
- **On `out_valid & out_ready`**
  - If `!done`: `val <= rest`, `cnt <= cnt+1`.
  - If `done`: the sequence is complete. The next state is EMIT if a new word is accepted in the same cycle, otherwise IDLE.
- **`in_ready`**: asserted in IDLE, or in EMIT when `out_valid & out_ready & out_last`. This allows back-to-back words with no bubble. It is forced to 0 while `reset` is low.
- **`out_len`**: equals `cnt` on the last byte. Sequences are bounded at 5 (i32) and 10 (i64).
  - `cnt` exceeding the bound for the latched width is a design error and is covered by a bench assertion.
- **Backpressure**: while `out_valid & !out_ready`, the values of `out_data`, `out_last`, `out_len` and the internal state are held stable.
- **Reset mid-sequence**: discards the remaining bytes. No partial flush.

## Timing
- Reset values:
  - state IDLE.
  - `out_valid` 0, `out_data` 0x00, `out_last` 0, `out_len` 0.
  - `val` 0, `cnt` 0.
  - `in_ready` is 0 while reset is asserted and 1 on the first cycle after release.
- Latency: the first byte is valid in the cycle after input acceptance. `out_valid` and `val` are registered.
- Throughput: 1 byte/cycle while `out_ready` is high. An N-byte word occupies N cycles.
- Simultaneous events: the last-byte handshake and a new input handshake in the same cycle start the new word's first byte on the next cycle.
- `in_value`, `in_is64` and `in_signed` are sampled only at the input handshake. Changes on these ports at other times are ignored.

## Structure
- Shared header (alongside `cpu.vh`):
  - width-select constants `LEB128_I32 = 0`, `LEB128_I64 = 1`.
  - `LEB128_MAX_I32 = 5`, `LEB128_MAX_I64 = 10`.
  - the existing `i32`/`i64` type codes, for callers mapping stack entries (`[65:64]`) to `in_is64`.
- One combinational sub-module, `leb128_step`, is natural:
  - inputs: `val` and `signed_q`.
  - outputs: `rest`, `done` and the output byte.
  - it keeps the termination rule in one place for reuse and unit testing.

## Test plan
- Unsigned i32 624485 with `out_ready` held 1 → E5, 8E, 26. `out_last` is set on 26 only, with `out_len` = 3.
- Signed i64 -123456 → C0, BB, 78, `out_len` 3.
- Signed i32 in two cases:
  - value 64 → C0, 00. The sign-bit rule forces a second byte.
  - value -1 (0xFFFFFFFF) → 7F, `out_len` 1.
- Extremes:
  - unsigned i64 0xFFFF_FFFF_FFFF_FFFF → FF ×9 then 01, `out_len` 10.
  - signed i64 0x8000_0000_0000_0000 → 80 ×9 then 7F, `out_len` 10.
- Backpressure and back-to-back:
  - stimulus: `out_ready` toggles randomly while encoding 624485, with a second word (signed i32 0, expected 00) offered continuously.
  - `out_data` must stay stable while stalled.
  - word 2 must be accepted in the same cycle as 26 is taken, and 00 must appear the next cycle.
- Reset mid-sequence: `reset` is driven low after E5 is taken.
  - In the next cycle, `out_valid` must be 0 and `in_ready` must be 0 while `reset` is held low.
  - On the first cycle after release, `in_ready` must be 1 and no stale bytes may be emitted.
